// File: rtl/rrf_alloc_unit.sv
// In-order rename/ROB entry allocator: one grant per cycle, reclaims on commit.
// Optional flush recovery is compiled in with `define RRF_FLUSH_EN.
module rrf_alloc_unit #(
    parameter int RRF_NUM            = 64,
    parameter int RRF_SEL            = 6,
    parameter bit CHK_ILLEGAL_COMMIT = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               dp1_req_i,
    input  logic               stall_dp_i,
    input  logic               comnum_i,
`ifdef RRF_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic [RRF_SEL-1:0] dp1_addr_o,
    output logic               dp1_grant_o,
    output logic               allocatable_o,
    output logic [RRF_SEL:0]   freenum_o,
    output logic [RRF_SEL-1:0] rrfptr_o,
    output logic               nextrrfcyc_o,
    output logic [RRF_SEL-1:0] commit_ptr_o
);

    localparam logic [RRF_SEL:0]   FREE_MAX = (RRF_SEL+1)'(RRF_NUM);
    localparam logic [RRF_SEL:0]   FREE_ONE = (RRF_SEL+1)'(1);
    localparam logic [RRF_SEL-1:0] PTR_ONE  = RRF_SEL'(1);
    localparam logic [RRF_SEL-1:0] PTR_LAST = RRF_SEL'(RRF_NUM - 1);

    logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
    logic [RRF_SEL-1:0] commit_ptr_q, commit_ptr_d;
    logic [RRF_SEL:0]   freenum_q, freenum_d;
    logic               nextrrfcyc_q, nextrrfcyc_d;
    logic               com_cyc_q, com_cyc_d;
    logic               allocatable;
    logic               grant;
    logic               com_ok;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        allocatable  = (freenum_q != '0);
        grant        = dp1_req_i & ~stall_dp_i & allocatable;
`ifdef RRF_FLUSH_EN
        grant        = grant & ~flush_i;
`endif
        // A commit with nothing outstanding is dropped rather than corrupting the count.
        com_ok       = comnum_i & (freenum_q != FREE_MAX);

        commit_ptr_d = commit_ptr_q;
        com_cyc_d    = com_cyc_q;
        rrfptr_d     = rrfptr_q;
        nextrrfcyc_d = nextrrfcyc_q;
        freenum_d    = freenum_q;

        if (com_ok) begin
            commit_ptr_d = commit_ptr_q + PTR_ONE;
            if (commit_ptr_q == PTR_LAST) begin
                com_cyc_d = ~com_cyc_q;
            end
        end

        if (grant) begin
            rrfptr_d = rrfptr_q + PTR_ONE;
            if (rrfptr_q == PTR_LAST) begin
                nextrrfcyc_d = ~nextrrfcyc_q;
            end
        end

        case ({com_ok, grant})
            2'b10:   freenum_d = freenum_q + FREE_ONE;
            2'b01:   freenum_d = freenum_q - FREE_ONE;
            default: freenum_d = freenum_q;
        endcase

`ifdef RRF_FLUSH_EN
        // Squash: the allocation pointer snaps back to the post-commit head, ring empty.
        if (flush_i) begin
            rrfptr_d     = commit_ptr_d;
            nextrrfcyc_d = com_cyc_d;
            freenum_d    = FREE_MAX;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rrfptr_q     <= '0;
            commit_ptr_q <= '0;
            freenum_q    <= FREE_MAX;
            nextrrfcyc_q <= 1'b0;
            com_cyc_q    <= 1'b0;
        end else begin
            rrfptr_q     <= rrfptr_d;
            commit_ptr_q <= commit_ptr_d;
            freenum_q    <= freenum_d;
            nextrrfcyc_q <= nextrrfcyc_d;
            com_cyc_q    <= com_cyc_d;
        end
    end

    assign dp1_addr_o    = rrfptr_q;
    assign dp1_grant_o   = grant;
    assign allocatable_o = allocatable;
    assign freenum_o     = freenum_q;
    assign rrfptr_o      = rrfptr_q;
    assign nextrrfcyc_o  = nextrrfcyc_q;
    assign commit_ptr_o  = commit_ptr_q;

    illegal_commit_a: assert property (@(posedge clk_i) disable iff (!reset_n_i || !CHK_ILLEGAL_COMMIT)
        !(comnum_i && freenum_q == FREE_MAX))
    else $error("rrf_alloc_unit: commit with no outstanding entries");

    // Occupancy equals pointer distance; freenum disambiguates full from empty.
    occupancy_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (rrfptr_q - commit_ptr_q) == RRF_SEL'(FREE_MAX - freenum_q))
    else $error("rrf_alloc_unit: pointer distance disagrees with free count");

endmodule

// File: tb/tb_rrf_alloc_unit.sv
// Directed bench for rrf_alloc_unit: fill, full/commit race, steady state,
// empty-commit drop, optional flush (RRF_FLUSH_EN) and asynchronous reset.
module tb_rrf_alloc_unit;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       dp1_req_i;
    logic       stall_dp_i;
    logic       comnum_i;
`ifdef RRF_FLUSH_EN
    logic       flush_i;
`endif
    logic [5:0] dp1_addr_o;
    logic       dp1_grant_o;
    logic       allocatable_o;
    logic [6:0] freenum_o;
    logic [5:0] rrfptr_o;
    logic       nextrrfcyc_o;
    logic [5:0] commit_ptr_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    // The deliberate empty-ring commit below must not raise the simulation assertion.
    rrf_alloc_unit #(
        .RRF_NUM           (64),
        .RRF_SEL           (6),
        .CHK_ILLEGAL_COMMIT(1'b0)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .dp1_req_i    (dp1_req_i),
        .stall_dp_i   (stall_dp_i),
        .comnum_i     (comnum_i),
`ifdef RRF_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .dp1_addr_o   (dp1_addr_o),
        .dp1_grant_o  (dp1_grant_o),
        .allocatable_o(allocatable_o),
        .freenum_o    (freenum_o),
        .rrfptr_o     (rrfptr_o),
        .nextrrfcyc_o (nextrrfcyc_o),
        .commit_ptr_o (commit_ptr_o)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply inputs at the falling edge; combinational outputs are sampled 1 unit later.
    task automatic drive(input logic req, input logic stall, input logic com);
        @(negedge clk_i);
        dp1_req_i  = req;
        stall_dp_i = stall;
        comnum_i   = com;
        #1;
    endtask

    task automatic check_state(input string tag, input int unsigned rp, input int unsigned cp,
                               input int unsigned fn, input int unsigned cyc);
        check({tag, ".rrfptr"},     rrfptr_o,     rp);
        check({tag, ".commit_ptr"}, commit_ptr_o, cp);
        check({tag, ".freenum"},    freenum_o,    fn);
        check({tag, ".nextrrfcyc"}, nextrrfcyc_o, cyc);
    endtask

    initial begin
        reset_n_i  = 1'b0;
        dp1_req_i  = 1'b0;
        stall_dp_i = 1'b0;
        comnum_i   = 1'b0;
`ifdef RRF_FLUSH_EN
        flush_i    = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        #1;
        check_state("reset", 0, 0, 64, 0);
        check("reset.allocatable", allocatable_o, 1);
        check("reset.grant_idle",  dp1_grant_o,   0);

        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Stall blocks an otherwise legal request and leaves the pointer alone.
        drive(1'b1, 1'b1, 1'b0);
        check("stall.grant", dp1_grant_o, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("stall.rrfptr", rrfptr_o, 0);

        // Fill the ring: 64 back-to-back grants at indices 0..63.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check($sformatf("fill.addr%0d", i),  dp1_addr_o,  i);
            check($sformatf("fill.grant%0d", i), dp1_grant_o, 1);
        end
        drive(1'b1, 1'b0, 1'b0);
        check_state("full", 0, 0, 0, 1);
        check("full.allocatable", allocatable_o, 0);
        check("full.grant",       dp1_grant_o,   0);

        // Same-cycle commit cannot satisfy a request against a full ring.
        drive(1'b1, 1'b0, 1'b1);
        check("race.grant", dp1_grant_o, 0);
        drive(1'b1, 1'b0, 1'b0);
        check("race.freenum", freenum_o,   1);
        check("race.grant2",  dp1_grant_o, 1);
        check("race.addr",    dp1_addr_o,  0);
        drive(1'b0, 1'b0, 1'b0);
        check_state("race.after", 1, 1, 0, 1);

        // Retire 10 entries, then grant+commit together for 5 cycles.
        repeat (10) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_state("ten", 1, 11, 10, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            check($sformatf("steady.grant%0d", i), dp1_grant_o, 1);
            check($sformatf("steady.addr%0d", i),  dp1_addr_o,  1 + i);
        end
        drive(1'b0, 1'b0, 1'b0);
        check_state("steady", 6, 16, 10, 1);

        // Drain to empty (commit pointer wraps 63->0), then an illegal commit is ignored.
        repeat (54) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_state("empty", 6, 6, 64, 1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_state("illegal", 6, 6, 64, 1);

`ifdef RRF_FLUSH_EN
        // Build rrfptr=40, commit_ptr=30, then flush with a concurrent commit.
        repeat (34) drive(1'b1, 1'b0, 1'b0);
        repeat (24) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_state("preflush", 40, 30, 54, 1);
        @(negedge clk_i);
        dp1_req_i  = 1'b1;
        stall_dp_i = 1'b0;
        comnum_i   = 1'b1;
        flush_i    = 1'b1;
        #1;
        check("flush.grant", dp1_grant_o, 0);
        @(negedge clk_i);
        flush_i = 1'b0;
        dp1_req_i = 1'b0;
        comnum_i  = 1'b0;
        #1;
        check_state("flush", 31, 31, 64, 1);
        // 50 grants from 31 wrap the allocation pointer to 17 and flip its parity.
        repeat (50) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_state("pre_rst", 17, 31, 14, 0);
`else
        repeat (11) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_state("pre_rst", 17, 6, 53, 1);
`endif

        // Asynchronous reset mid-cycle while a request is pending.
        @(negedge clk_i);
        dp1_req_i = 1'b1;
        #2;
        reset_n_i = 1'b0;
        #1;
        check_state("midrst", 0, 0, 64, 0);
        check("midrst.addr", dp1_addr_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check("restart.addr0",  dp1_addr_o,  0);
        check("restart.grant0", dp1_grant_o, 1);
        drive(1'b1, 1'b0, 1'b0);
        check("restart.addr1", dp1_addr_o, 1);
        check("restart.freenum", freenum_o, 63);
        drive(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
